// File: rtl/ddr_rd_burst_ctrl.sv
// DDR read master: walks one frame buffer as fixed-length read bursts,
// one burst outstanding, gated by the FIFO write-side water level, and
// forwards every returned beat into the FIFO with one cycle of latency.
module ddr_rd_burst_ctrl #(
   parameter int unsigned             ADDR_WIDTH  = 28,
   parameter int unsigned             DATA_WIDTH  = 256,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
   parameter int unsigned             FRAME_BEATS = 115200,
   parameter int unsigned             BURST_LEN   = 16,
   parameter int unsigned             FILL_THRESH = 224
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic [8:0]            fifo_wr_water_level,
   output logic [ADDR_WIDTH-1:0] ar_addr,
   output logic [7:0]            ar_len,
   output logic                  ar_valid,
   input  logic                  ar_ready,
   input  logic [DATA_WIDTH-1:0] r_data,
   input  logic                  r_valid,
   input  logic                  r_last,
   output logic                  r_ready,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  len_err
);

   localparam int unsigned REM_W      = $clog2(FRAME_BEATS + 1);
   localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, SETTLE} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [REM_W-1:0]        remain_q, remain_d;
   logic [8:0]              n_q, n_d;
   logic [8:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
   logic [7:0]              ar_len_q, ar_len_d;
   logic                    wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    len_err_q, len_err_d;
   logic                    pend_q, pend_d;
   logic                    settle_q, settle_d;

   logic [8:0]              burst_n;
   logic                    level_ok;

   assign burst_n  = ({{(32-REM_W){1'b0}}, remain_q} >= BURST_LEN) ? 9'(BURST_LEN) : 9'(remain_q);
   assign level_ok = ({23'd0, fifo_wr_water_level} <= FILL_THRESH);

   assign ar_addr      = ar_addr_q;
   assign ar_len       = ar_len_q;
   assign ar_valid     = (state_q == ADDR);
   assign r_ready      = (state_q == DATA);
   assign fifo_wr_en   = wr_en_q;
   assign fifo_wr_data = wr_data_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign len_err      = len_err_q;

   // Next-state and datapath decode for the burst walker.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      ar_addr_d = ar_addr_q;
      ar_len_d  = ar_len_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      len_err_d = len_err_q;
      pend_d    = pend_q;
      settle_d  = settle_q;

      // A restart request mid-frame is parked until the next CHECK so an
      // accepted burst is always fully drained first.
      if (frame_start && state_q != IDLE) pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d   = CHECK;
               addr_d    = BASE_ADDR;
               remain_d  = REM_W'(FRAME_BEATS);
               len_err_d = 1'b0;
               busy_d    = 1'b1;
               pend_d    = 1'b0;
            end
         end
         CHECK: begin
            if (frame_start || pend_q) begin
               // Restart takes priority over completing the frame.
               addr_d    = BASE_ADDR;
               remain_d  = REM_W'(FRAME_BEATS);
               len_err_d = 1'b0;
               pend_d    = 1'b0;
            end else if (remain_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (level_ok) begin
               state_d   = ADDR;
               ar_addr_d = addr_q;
               n_d       = burst_n;
               ar_len_d  = 8'(burst_n - 9'd1);
            end
         end
         ADDR: begin
            if (ar_ready) begin
               state_d  = DATA;
               addr_d   = addr_q + ADDR_WIDTH'(32'(n_q) * BEAT_BYTES);
               remain_d = remain_q - REM_W'(n_q);
               cnt_d    = '0;
            end
         end
         DATA: begin
            if (r_valid) begin
               wr_en_d   = 1'b1;
               wr_data_d = r_data;
               if (r_last) begin
                  if (cnt_q != n_q - 9'd1) len_err_d = 1'b1;
                  state_d  = SETTLE;
                  settle_d = 1'b0;
               end else begin
                  if (cnt_q >= n_q - 9'd1) len_err_d = 1'b1;
                  if (cnt_q != '1) cnt_d = cnt_q + 9'd1;
               end
            end
         end
         SETTLE: begin
            if (settle_q) begin
               state_d  = CHECK;
               settle_d = 1'b0;
            end else begin
               settle_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= BASE_ADDR;
         remain_q  <= '0;
         n_q       <= '0;
         cnt_q     <= '0;
         ar_addr_q <= BASE_ADDR;
         ar_len_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
         pend_q    <= 1'b0;
         settle_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         ar_addr_q <= ar_addr_d;
         ar_len_q  <= ar_len_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         len_err_q <= len_err_d;
         pend_q    <= pend_d;
         settle_q  <= settle_d;
      end
   end

endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// Self-checking bench for ddr_rd_burst_ctrl: a randomized read slave
// serves bursts, and per-scenario tasks compare observed bursts, FIFO
// writes and status against a frame model computed from burst arithmetic.
module tb_ddr_rd_burst_ctrl;

   localparam int unsigned AW   = 28;
   localparam int unsigned DW   = 256;
   localparam logic [AW-1:0] BASE = 28'hFFFFC00;
   localparam int unsigned FB   = 40;
   localparam int unsigned BL   = 16;
   localparam int unsigned FT   = 224;

   logic          clk, rst_n, frame_start;
   logic [8:0]    level;
   logic [AW-1:0] ar_addr;
   logic [7:0]    ar_len;
   logic          ar_valid, ar_ready;
   logic [DW-1:0] r_data;
   logic          r_valid, r_last, r_ready;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   logic          busy, frame_done, len_err;

   ddr_rd_burst_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
      .FRAME_BEATS(FB), .BURST_LEN(BL), .FILL_THRESH(FT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .fifo_wr_water_level(level),
      .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .busy(busy), .frame_done(frame_done), .len_err(len_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [AW+7:0] got_b[$];
   logic [AW+7:0] exp_b[$];
   logic [DW-1:0] sent[$];
   logic [DW-1:0] got_w[$];
   int fd_cnt, av_cnt, stab_err;

   int force_delay    = -1;
   int beats_override = 0;
   int restart_at     = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output monitor: records FIFO writes, frame_done pulses, ar_valid cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (fifo_wr_en) got_w.push_back(fifo_wr_data);
         if (frame_done) fd_cnt++;
         if (ar_valid) av_cnt++;
      end
   end

   // Read slave: random address latency, random beat gaps, optional faults.
   initial begin
      logic [AW-1:0] a0;
      logic [7:0]    l0;
      logic [DW-1:0] rd;
      int dly, nb, b;
      bit rs;
      ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_data = '0; rs = 1'b0;
      forever begin
         @(negedge clk);
         if (ar_valid && rst_n) begin
            a0 = ar_addr; l0 = ar_len;
            if (force_delay >= 0) begin dly = force_delay; force_delay = -1; end
            else dly = $urandom_range(0, 3);
            for (int k = 0; k < dly && rst_n; k++) begin
               @(negedge clk);
               if (rst_n && (ar_addr !== a0 || ar_len !== l0 || ar_valid !== 1'b1)) stab_err++;
            end
            if (rst_n) begin
               ar_ready = 1'b1;
               got_b.push_back({ar_addr, ar_len});
               @(negedge clk);
               ar_ready = 1'b0;
               nb = (beats_override != 0) ? beats_override : int'(l0) + 1;
               beats_override = 0;
               b = 0;
               while (b < nb && rst_n) begin
                  if ($urandom_range(0, 3) != 0) begin
                     for (int w = 0; w < DW / 32; w++) rd[w*32 +: 32] = $urandom;
                     r_valid = 1'b1; r_data = rd; r_last = (b == nb - 1);
                     sent.push_back(rd);
                     if (restart_at >= 0 && b == restart_at) begin
                        frame_start = 1'b1; restart_at = -1; rs = 1'b1;
                     end
                     b++;
                  end else begin
                     r_valid = 1'b0; r_last = 1'b0;
                  end
                  @(negedge clk);
                  if (rs) begin frame_start = 1'b0; rs = 1'b0; end
               end
               r_valid = 1'b0; r_last = 1'b0;
            end
         end
      end
   end

   // Frame model: burst list from plain arithmetic on the frame geometry.
   task automatic model_frame();
      int unsigned rem, n;
      logic [AW-1:0] a;
      rem = FB; a = BASE;
      while (rem > 0) begin
         n = (rem < BL) ? rem : BL;
         exp_b.push_back({a, 8'(n - 1)});
         a = a + AW'(n * (DW / 8));
         rem -= n;
      end
   endtask

   task automatic clear_sb();
      got_b.delete(); exp_b.delete(); sent.delete(); got_w.delete();
      fd_cnt = 0; av_cnt = 0; stab_err = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk); #1;
         if (fd_cnt >= target) begin ok = 1'b1; break; end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_start = 1'b0; level = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({ar_valid, r_ready, fifo_wr_en, busy, frame_done, len_err} !== 6'b0) begin
         n_fail++; $display("FAIL reset_flags got=%b exp=000000", {ar_valid, r_ready, fifo_wr_en, busy, frame_done, len_err});
      end
      n_checks++;
      if (ar_addr !== BASE || ar_len !== 8'd0) begin
         n_fail++; $display("FAIL reset_ar got=%h/%0d exp=%h/0", ar_addr, ar_len, BASE);
      end
      n_checks++;
      if (fifo_wr_data !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", fifo_wr_data); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame();
      bit ok; int nbad;
      clear_sb(); model_frame();
      level = 9'($urandom_range(0, FT));
      pulse_start();
      n_checks++;
      if (busy !== 1'b1 || len_err !== 1'b0) begin
         n_fail++; $display("FAIL frame_start_status got busy=%b len_err=%b exp 1/0", busy, len_err);
      end
      wait_done(1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL frame_timeout got done=%0d exp=1", fd_cnt); end
      nbad = 0;
      foreach (exp_b[i]) if (i >= got_b.size() || got_b[i] !== exp_b[i]) nbad++;
      n_checks++;
      if (got_b.size() != exp_b.size() || nbad != 0) begin
         n_fail++; $display("FAIL frame_bursts got=%0d (bad %0d) exp=%0d", got_b.size(), nbad, exp_b.size());
      end
      nbad = 0;
      foreach (sent[i]) if (i >= got_w.size() || got_w[i] !== sent[i]) nbad++;
      n_checks++;
      if (got_w.size() != FB || sent.size() != FB || nbad != 0) begin
         n_fail++; $display("FAIL frame_writes got=%0d (bad %0d) exp=%0d", got_w.size(), nbad, FB);
      end
      n_checks++;
      if (fd_cnt != 1 || busy !== 1'b0 || len_err !== 1'b0) begin
         n_fail++; $display("FAIL frame_end got done=%0d busy=%b len_err=%b exp 1/0/0", fd_cnt, busy, len_err);
      end
   endtask

   task automatic test_threshold();
      bit ok; int nbad;
      clear_sb(); model_frame();
      level = 9'(FT + 1);
      pulse_start();
      repeat (20) @(negedge clk);
      n_checks++;
      if (av_cnt != 0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL thresh_block got av=%0d busy=%b exp 0/1", av_cnt, busy);
      end
      level = 9'(FT);
      @(negedge clk);
      n_checks++;
      if (ar_valid !== 1'b1) begin n_fail++; $display("FAIL thresh_release got ar_valid=%b exp=1", ar_valid); end
      wait_done(1, ok);
      nbad = 0;
      foreach (exp_b[i]) if (i >= got_b.size() || got_b[i] !== exp_b[i]) nbad++;
      n_checks++;
      if (!ok || got_b.size() != exp_b.size() || nbad != 0 || got_w.size() != FB) begin
         n_fail++; $display("FAIL thresh_frame got ok=%0d bursts=%0d bad=%0d writes=%0d exp 1/%0d/0/%0d",
                            ok, got_b.size(), nbad, got_w.size(), exp_b.size(), FB);
      end
   endtask

   task automatic test_ar_stall();
      bit ok; int nbad;
      clear_sb(); model_frame();
      level = '0; force_delay = 10;
      pulse_start();
      wait_done(1, ok);
      n_checks++;
      if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable got=%0d changes exp=0", stab_err); end
      nbad = 0;
      foreach (exp_b[i]) if (i >= got_b.size() || got_b[i] !== exp_b[i]) nbad++;
      n_checks++;
      if (!ok || got_b.size() != exp_b.size() || nbad != 0 || got_w.size() != FB) begin
         n_fail++; $display("FAIL stall_frame got ok=%0d bursts=%0d bad=%0d writes=%0d exp 1/%0d/0/%0d",
                            ok, got_b.size(), nbad, got_w.size(), exp_b.size(), FB);
      end
   endtask

   task automatic test_restart();
      bit ok; int nbad;
      clear_sb();
      exp_b.push_back({BASE, 8'(BL - 1)});
      model_frame();
      level = '0; restart_at = BL - 5;
      pulse_start();
      wait_done(1, ok);
      nbad = 0;
      foreach (exp_b[i]) if (i >= got_b.size() || got_b[i] !== exp_b[i]) nbad++;
      n_checks++;
      if (!ok || got_b.size() != exp_b.size() || nbad != 0) begin
         n_fail++; $display("FAIL restart_bursts got ok=%0d n=%0d bad=%0d exp n=%0d", ok, got_b.size(), nbad, exp_b.size());
      end
      nbad = 0;
      foreach (sent[i]) if (i >= got_w.size() || got_w[i] !== sent[i]) nbad++;
      n_checks++;
      if (got_w.size() != BL + FB || nbad != 0) begin
         n_fail++; $display("FAIL restart_writes got=%0d bad=%0d exp=%0d", got_w.size(), nbad, BL + FB);
      end
      n_checks++;
      if (fd_cnt != 1) begin n_fail++; $display("FAIL restart_done got=%0d exp=1", fd_cnt); end
   endtask

   task automatic test_len_err(input int beats);
      bit ok; int nbad;
      clear_sb(); model_frame();
      level = '0; beats_override = beats;
      pulse_start();
      wait_done(1, ok);
      nbad = 0;
      foreach (exp_b[i]) if (i >= got_b.size() || got_b[i] !== exp_b[i]) nbad++;
      n_checks++;
      if (!ok || got_b.size() != exp_b.size() || nbad != 0) begin
         n_fail++; $display("FAIL lenerr_bursts beats=%0d got ok=%0d n=%0d bad=%0d", beats, ok, got_b.size(), nbad);
      end
      n_checks++;
      if (got_w.size() != FB - BL + beats) begin
         n_fail++; $display("FAIL lenerr_writes got=%0d exp=%0d", got_w.size(), FB - BL + beats);
      end
      n_checks++;
      if (len_err !== 1'b1 || fd_cnt != 1) begin
         n_fail++; $display("FAIL lenerr_flag got len_err=%b done=%0d exp 1/1", len_err, fd_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int i;
      clear_sb();
      level = '0;
      pulse_start();
      for (i = 0; i < 1000 && got_w.size() < 5; i++) @(negedge clk);
      n_checks++;
      if (got_w.size() < 5) begin n_fail++; $display("FAIL rstmid_progress got=%0d exp>=5", got_w.size()); end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ar_valid, r_ready, fifo_wr_en, busy, frame_done, len_err} !== 6'b0 ||
          ar_addr !== BASE || ar_len !== 8'd0 || fifo_wr_data !== '0) begin
         n_fail++; $display("FAIL rstmid_values got flags=%b addr=%h len=%0d exp 000000/%h/0",
                            {ar_valid, r_ready, fifo_wr_en, busy, frame_done, len_err}, ar_addr, ar_len, BASE);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      av_cnt = 0; fd_cnt = 0;
      repeat (10) @(negedge clk);
      n_checks++;
      if (av_cnt != 0 || fd_cnt != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_idle got av=%0d done=%0d busy=%b exp 0/0/0", av_cnt, fd_cnt, busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int nbad;
      clear_sb(); model_frame(); model_frame();
      level = 9'($urandom_range(0, FT));
      pulse_start();
      wait_done(1, ok);
      pulse_start();
      wait_done(2, ok);
      nbad = 0;
      foreach (exp_b[i]) if (i >= got_b.size() || got_b[i] !== exp_b[i]) nbad++;
      n_checks++;
      if (!ok || got_b.size() != exp_b.size() || nbad != 0) begin
         n_fail++; $display("FAIL b2b_bursts got ok=%0d n=%0d bad=%0d exp n=%0d", ok, got_b.size(), nbad, exp_b.size());
      end
      nbad = 0;
      foreach (sent[i]) if (i >= got_w.size() || got_w[i] !== sent[i]) nbad++;
      n_checks++;
      if (got_w.size() != 2 * FB || nbad != 0 || fd_cnt != 2) begin
         n_fail++; $display("FAIL b2b_writes got=%0d bad=%0d done=%0d exp %0d/0/2", got_w.size(), nbad, fd_cnt, 2 * FB);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_threshold();
      test_ar_stall();
      test_restart();
      test_len_err(9);
      test_frame();
      test_len_err(18);
      test_frame();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
